// File: rtl/pipe_scroller.sv
// Scrolling multi-pipe obstacle renderer for the VGA path: pipes move left once per
// frame, respawn off the right edge with an LFSR-chosen gap, and drive registered RGB.
module pipe_scroller #(
  parameter int          H_ACTIVE     = 640,
  parameter int          V_ACTIVE     = 480,
  parameter int          NUM_PIPES    = 3,
  parameter int          PIPE_WIDTH   = 50,
  parameter int          PIPE_SPACING = 220,
  parameter int          GAP_HEIGHT   = 120,
  parameter int          GAP_MIN      = 40,
  parameter logic [7:0]  GAP_MASK     = 8'hFF,
  parameter int          SPEED        = 2,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic       clk,
  input  logic       clear,
  input  logic [9:0] h_counter,
  input  logic [9:0] v_counter,
  input  logic       run,
  output logic [2:0] rgb,
  output logic       frame_tick,
  output logic [7:0] pipes_passed
);

  localparam logic [10:0] SPEED_W   = 11'(SPEED);
  localparam logic [10:0] WIDTH_W   = 11'(PIPE_WIDTH);
  localparam logic [10:0] WRAP_W    = 11'(NUM_PIPES * PIPE_SPACING - SPEED);
  localparam logic [9:0]  GAP_RESET = 10'((V_ACTIVE - GAP_HEIGHT) / 2);
  localparam logic [9:0]  GAP_H     = 10'(GAP_HEIGHT);
  localparam logic [9:0]  GAP_MIN_W = 10'(GAP_MIN);
  localparam logic [9:0]  H_MAX     = 10'(H_ACTIVE);
  localparam logic [9:0]  V_MAX     = 10'(V_ACTIVE);

  logic [10:0]          r_reg       [NUM_PIPES];
  logic [9:0]           gap_top_reg [NUM_PIPES];
  logic [15:0]          lfsr_reg;
  logic                 tick_cond_reg;
  logic                 frame_tick_reg;
  logic [2:0]           rgb_reg;
  logic [7:0]           pipes_passed_reg;

  logic                 tick_cond;
  logic                 update;
  logic                 visible;
  logic                 lfsr_fb;
  logic [9:0]           new_gap;
  logic [10:0]          h_ext;
  logic [7:0]           respawn_count;
  logic [NUM_PIPES-1:0] respawn;
  logic [NUM_PIPES-1:0] hit;

  assign tick_cond = (h_counter == 10'd0) && (v_counter == V_MAX);
  assign update    = frame_tick_reg && run;
  assign visible   = (h_counter < H_MAX) && (v_counter < V_MAX);
  assign lfsr_fb   = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];
  assign new_gap   = GAP_MIN_W + {2'b00, lfsr_reg[7:0] & GAP_MASK};
  assign h_ext     = {1'b0, h_counter};

  // Per-pipe column/gap test; the left bound is rearranged to avoid a negative edge.
  generate
    for (genvar gi = 0; gi < NUM_PIPES; gi++) begin : g_pipe
      assign respawn[gi] = (r_reg[gi] <= SPEED_W);
      assign hit[gi] = (h_ext + WIDTH_W >= r_reg[gi]) && (h_ext < r_reg[gi]) &&
                       ((v_counter < gap_top_reg[gi]) ||
                        (v_counter >= gap_top_reg[gi] + GAP_H));
    end
  endgenerate

  always_comb begin
    respawn_count = 8'd0;
    for (int i = 0; i < NUM_PIPES; i++) begin
      respawn_count = respawn_count + 8'(respawn[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      tick_cond_reg    <= 1'b0;
      frame_tick_reg   <= 1'b0;
      rgb_reg          <= 3'b000;
      pipes_passed_reg <= 8'd0;
      lfsr_reg         <= LFSR_SEED;
      for (int i = 0; i < NUM_PIPES; i++) begin
        r_reg[i]       <= 11'(H_ACTIVE + PIPE_WIDTH + i * PIPE_SPACING);
        gap_top_reg[i] <= GAP_RESET;
      end
    end else begin
      tick_cond_reg  <= tick_cond;
      frame_tick_reg <= tick_cond && !tick_cond_reg;
      rgb_reg        <= (visible && (|hit)) ? 3'b010 : 3'b000;
      // Positions only move in the blanking cycle right after the tick.
      if (update) begin
        lfsr_reg         <= {lfsr_reg[14:0], lfsr_fb};
        pipes_passed_reg <= pipes_passed_reg + respawn_count;
        for (int i = 0; i < NUM_PIPES; i++) begin
          if (respawn[i]) begin
            r_reg[i]       <= r_reg[i] + WRAP_W;
            gap_top_reg[i] <= new_gap;
          end else begin
            r_reg[i]       <= r_reg[i] - SPEED_W;
          end
        end
      end
    end
  end

  assign rgb          = rgb_reg;
  assign frame_tick   = frame_tick_reg;
  assign pipes_passed = pipes_passed_reg;

endmodule

// File: tb/tb_pipe_scroller.sv
// Directed bench for pipe_scroller: a behavioural pipe/LFSR model feeds an rgb
// scoreboard, plus direct checks of frame_tick pulses and the respawn counter.
module tb_pipe_scroller;

  logic       clk = 1'b0;
  logic       clear = 1'b0;
  logic [9:0] h_counter = 10'd1;
  logic [9:0] v_counter = 10'd480;
  logic       run = 1'b0;
  logic [2:0] rgb;
  logic       frame_tick;
  logic [7:0] pipes_passed;

  int total = 0;
  int bad = 0;
  int pulse_cnt = 0;

  int          m_r   [3];
  int          m_gap [3];
  logic [15:0] m_lfsr;
  int          m_pp;

  typedef struct {
    string      tag;
    logic [2:0] exp;
    int         h;
    int         v;
  } pix_t;
  pix_t exp_q [$];

  pipe_scroller dut (
    .clk          (clk),
    .clear        (clear),
    .h_counter    (h_counter),
    .v_counter    (v_counter),
    .run          (run),
    .rgb          (rgb),
    .frame_tick   (frame_tick),
    .pipes_passed (pipes_passed)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_tick === 1'b1) pulse_cnt++;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_r[i]   = 690 + i * 220;
      m_gap[i] = 180;
    end
    m_lfsr = 16'hACE1;
    m_pp   = 0;
  endtask

  task automatic model_frame();
    logic fb;
    for (int i = 0; i < 3; i++) begin
      if (m_r[i] <= 2) begin
        m_r[i]   = m_r[i] + 660 - 2;
        m_gap[i] = 40 + int'(m_lfsr[7:0]);
        m_pp++;
      end else begin
        m_r[i] = m_r[i] - 2;
      end
    end
    fb     = m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10];
    m_lfsr = {m_lfsr[14:0], fb};
  endtask

  function automatic logic [2:0] model_pix(int h, int v);
    if (h >= 640 || v >= 480) return 3'b000;
    for (int i = 0; i < 3; i++) begin
      if ((h + 50 >= m_r[i]) && (h < m_r[i]) && ((v < m_gap[i]) || (v >= m_gap[i] + 120)))
        return 3'b010;
    end
    return 3'b000;
  endfunction

  task automatic check(string tag, int obs, int exp);
    total++;
    $display("check %s: got %0d want %0d", tag, obs, exp);
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Drive one pixel, push its expected colour, then pop and compare one cycle later.
  task automatic probe(string tag, int h, int v);
    pix_t p;
    pix_t q;
    p.tag = tag; p.exp = model_pix(h, v); p.h = h; p.v = v;
    exp_q.push_back(p);
    h_counter = 10'(h);
    v_counter = 10'(v);
    @(posedge clk); #1;
    q = exp_q.pop_front();
    total++;
    $display("pixel %s h=%0d v=%0d: rgb=%b want %b", q.tag, q.h, q.v, rgb, q.exp);
    assert (rgb === q.exp) else begin
      bad++;
      $error("FAIL %s h=%0d v=%0d: rgb got %b want %b", q.tag, q.h, q.v, rgb, q.exp);
    end
    h_counter = 10'd1;
    v_counter = 10'd480;
  endtask

  task automatic give_ticks(int n);
    for (int k = 0; k < n; k++) begin
      h_counter = 10'd0;
      v_counter = 10'd480;
      @(posedge clk); #1;
      @(posedge clk); #1;
      if (run) model_frame();
      h_counter = 10'd1;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int p0;
    model_reset();

    // Reset
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check("reset_rgb", int'(rgb), 0);
    check("reset_pp", int'(pipes_passed), 0);
    check("reset_tick", int'(frame_tick), 0);
    probe("reset_offscreen", 639, 10);

    // Tick held for five cycles gives one pulse; re-arming gives one more
    p0 = pulse_cnt;
    h_counter = 10'd0;
    v_counter = 10'd480;
    @(posedge clk); #1;
    check("tick_first", int'(frame_tick), 1);
    @(posedge clk); #1;
    check("tick_second", int'(frame_tick), 0);
    repeat (3) begin @(posedge clk); #1; end
    check("tick_hold_pulses", pulse_cnt - p0, 1);
    h_counter = 10'd1;
    @(posedge clk); #1;
    h_counter = 10'd0;
    repeat (3) begin @(posedge clk); #1; end
    h_counter = 10'd1;
    @(posedge clk); #1;
    check("tick_rearm_pulses", pulse_cnt - p0, 2);

    // Thirty scrolling frames bring pipe 0 to r=630
    run = 1'b1;
    give_ticks(30);
    probe("p0_top", 600, 10);
    probe("p0_gap", 600, 200);
    probe("p0_bottom_edge", 629, 479);
    probe("p0_right_excl", 630, 479);
    probe("p0_gap_top_edge", 600, 179);
    probe("p0_gap_bot_edge", 600, 300);
    probe("hblank", 640, 10);

    // Up to the frame before the first respawn, then the respawn itself
    give_ticks(314);
    check("pp_before_respawn", int'(pipes_passed), m_pp & 255);
    probe("p0_r2_col0", 0, 10);
    probe("p0_r2_col1", 1, 10);
    probe("p0_r2_col2", 2, 10);
    give_ticks(1);
    check("pp_after_respawn", int'(pipes_passed), m_pp & 255);
    probe("resp_left_out", 609, 10);
    probe("resp_left_in", 610, 10);
    probe("resp_above_gap", 620, m_gap[0] - 1);
    probe("resp_gap_top", 620, m_gap[0]);
    probe("resp_gap_last", 620, m_gap[0] + 119);
    probe("resp_below_gap", 620, m_gap[0] + 120);

    // Frozen: pulses continue, scene and counter stay put
    run = 1'b0;
    p0 = pulse_cnt;
    give_ticks(10);
    check("frozen_pulses", pulse_cnt - p0, 10);
    check("frozen_pp", int'(pipes_passed), m_pp & 255);
    probe("frozen_left_out", 609, 10);
    probe("frozen_left_in", 610, 10);
    probe("frozen_gap_top", 620, m_gap[0]);
    probe("frozen_below_gap", 620, m_gap[0] + 120);

    // Resume; pipe 1 respawns on the 110th frame with a gap from the unadvanced LFSR
    run = 1'b1;
    give_ticks(110);
    check("pp_second_respawn", int'(pipes_passed), m_pp & 255);
    probe("p1_above_gap", 620, m_gap[1] - 1);
    probe("p1_gap_top", 620, m_gap[1]);
    probe("p1_below_gap", 620, m_gap[1] + 120);

    // Clear mid-line
    h_counter = 10'd300;
    v_counter = 10'd100;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    model_reset();
    check("midclear_rgb", int'(rgb), 0);
    check("midclear_pp", int'(pipes_passed), 0);
    check("midclear_tick", int'(frame_tick), 0);
    h_counter = 10'd1;
    v_counter = 10'd480;
    give_ticks(1);
    probe("post_clear_out", 637, 10);
    probe("post_clear_in", 638, 10);
    probe("post_clear_edge", 639, 10);
    probe("post_clear_gap", 639, 200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
